// File: rtl/rename_pkg.sv
// rename_pkg: shared constants and types for the rename-stage sequencing controller.
//   PREG_W       - physical register address width
//   ARCH_W       - architectural register address width
//   FREE_Q_DEPTH - default depth of the free-request queue
//   ren_state_e  - controller state (RUN / STALL / FLUSH)
package rename_pkg;

  localparam int PREG_W       = 5;
  localparam int ARCH_W       = 5;
  localparam int FREE_Q_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } ren_state_e;

endpackage

// File: rtl/rename_ctrl_fifo.sv
// free_req_fifo: first-word-fall-through queue holding physical registers waiting to be
// returned to the free list.
//   clk_i, reset_i   - clock, synchronous active-high reset (clears pointers and count)
//   push_i/push_data_i - enqueue request and data (ignored when full)
//   pop_i            - dequeue the head entry (ignored when empty)
//   head_o           - current head entry, valid whenever empty_o = 0
//   full_o, empty_o, count_o - occupancy status, all from registered state
module free_req_fifo #(
  parameter int DEPTH = rename_pkg::FREE_Q_DEPTH,
  parameter int W     = rename_pkg::PREG_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CW    = PTR_W + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  import rename_pkg::*;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data_i;
      // Depth is a power of two, so the pointer wraps naturally.
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is data only and carries no reset; occupancy is tracked by pointers/count.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rename_ctrl.sv
// rename_ctrl: sequencing controller for the rename stage and the physical-register free list.
//   Decode side   : dec_valid_i/dec_rd_wen_i/dec_rd_addr_i in, dec_ready_o out
//   Rename side   : ren_inst_valid_o (allocating fire)
//   Dispatch side : disp_ready_i credit in, disp_valid_o (fire delayed one cycle)
//   Free list     : fl_empty_i in, fl_free_en_o/fl_free_addr_o single free port out
//   Commit/squash : cmt_* and sq_* free requests with cmt_ready_o/sq_ready_o
//   Flush control : flush_i, sq_done_i
//   Statistics    : stall_empty_cnt_o saturating count of empty-free-list stall cycles
module rename_ctrl #(
  parameter int FREE_Q_DEPTH = rename_pkg::FREE_Q_DEPTH,
  parameter int PREG_W       = rename_pkg::PREG_W,
  parameter int CNT_W        = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        dec_valid_i,
  input  logic                        dec_rd_wen_i,
  input  logic [rename_pkg::ARCH_W-1:0] dec_rd_addr_i,
  output logic                        dec_ready_o,
  input  logic                        disp_ready_i,
  output logic                        ren_inst_valid_o,
  output logic                        disp_valid_o,
  input  logic                        fl_empty_i,
  output logic                        fl_free_en_o,
  output logic [PREG_W-1:0]           fl_free_addr_o,
  input  logic                        cmt_free_en_i,
  input  logic [PREG_W-1:0]           cmt_free_addr_i,
  output logic                        cmt_ready_o,
  input  logic                        sq_free_en_i,
  input  logic [PREG_W-1:0]           sq_free_addr_i,
  output logic                        sq_ready_o,
  input  logic                        flush_i,
  input  logic                        sq_done_i,
  output logic [CNT_W-1:0]            stall_empty_cnt_o
);
  import rename_pkg::*;

  localparam int QCNT_W = $clog2(FREE_Q_DEPTH) + 1;

  ren_state_e        state_q, state_d;
  logic              sq_done_seen_q, sq_done_seen_d;
  logic              disp_valid_q, disp_valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              needs_alloc;
  logic              free_prio;
  logic              fire;
  logic              stall_evt;
  logic              cmt_acc, sq_acc;
  logic              q_push, q_pop;
  logic [PREG_W-1:0] q_push_data, q_head;
  logic              q_full, q_empty;
  logic [QCNT_W-1:0] q_count;

  free_req_fifo #(
    .DEPTH (FREE_Q_DEPTH),
    .W     (PREG_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (q_push),
    .push_data_i (q_push_data),
    .pop_i       (q_pop),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

  // x0 is never renamed, so writes to it need no physical register.
  assign needs_alloc = dec_rd_wen_i & (dec_rd_addr_i != '0);
  assign stall_evt   = dec_valid_i & needs_alloc & fl_empty_i;

  // Near-full queue or flush gives the free port priority by blocking allocation.
  assign free_prio = (q_count >= QCNT_W'(FREE_Q_DEPTH - 1)) | (state_q == ST_FLUSH);

  assign dec_ready_o = ~reset_i & (state_q == ST_RUN) & disp_ready_i & ~flush_i &
                       (~needs_alloc | (~fl_empty_i & ~free_prio));
  assign fire             = dec_valid_i & dec_ready_o;
  assign ren_inst_valid_o = fire & needs_alloc;

  // The free list takes one pointer update per cycle: a free only goes out when no
  // allocation is happening.
  assign fl_free_en_o   = ~reset_i & ~q_empty & ~ren_inst_valid_o;
  assign fl_free_addr_o = fl_free_en_o ? q_head : '0;
  assign q_pop          = fl_free_en_o;

  // One enqueue per cycle; commit wins over squash.
  assign cmt_ready_o = ~reset_i & ~q_full;
  assign sq_ready_o  = ~reset_i & ~q_full & ~cmt_free_en_i;
  assign cmt_acc     = cmt_free_en_i & cmt_ready_o;
  assign sq_acc      = sq_free_en_i & sq_ready_o;

  // p0 requests are acknowledged but never reach the queue.
  assign q_push      = (cmt_acc & (cmt_free_addr_i != '0)) | (sq_acc & (sq_free_addr_i != '0));
  assign q_push_data = cmt_acc ? cmt_free_addr_i : sq_free_addr_i;

  // A fire in the cycle before a flush is killed as it reaches dispatch.
  assign disp_valid_o      = disp_valid_q & ~flush_i & (state_q != ST_FLUSH);
  assign stall_empty_cnt_o = stall_cnt_q;

  always_comb begin
    state_d        = state_q;
    sq_done_seen_d = 1'b0;
    disp_valid_d   = fire;
    stall_cnt_d    = stall_cnt_q;

    if (stall_evt && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_RUN: begin
        if (stall_evt) state_d = ST_STALL;
      end
      ST_STALL: begin
        if (!fl_empty_i) state_d = ST_RUN;
      end
      ST_FLUSH: begin
        // sq_done_i may pulse before the queue drains, so remember it.
        if ((sq_done_seen_q || sq_done_i) && q_empty) begin
          state_d = ST_RUN;
        end else begin
          sq_done_seen_d = sq_done_seen_q | sq_done_i;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (flush_i) begin
      state_d        = ST_FLUSH;
      sq_done_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= ST_RUN;
      sq_done_seen_q <= 1'b0;
      disp_valid_q   <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      sq_done_seen_q <= sq_done_seen_d;
      disp_valid_q   <= disp_valid_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_rename_ctrl.sv
// tb_rename_ctrl: directed scenarios plus randomized traffic for rename_ctrl, every cycle
// compared against a queue-based behavioural model of the controller.
module tb_rename_ctrl;

  localparam int DEPTH   = 4;
  localparam int CNT_MAX = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_wen, disp_ready, fl_empty;
  logic [4:0]  dec_rd;
  logic        cmt_en, sq_en, flush, sq_done;
  logic [4:0]  cmt_addr, sq_addr;
  logic        dec_ready, ren_iv, disp_valid, fl_en, cmt_ready, sq_ready;
  logic [4:0]  fl_addr;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  rename_ctrl #(.FREE_Q_DEPTH(DEPTH), .PREG_W(5), .CNT_W(16)) dut (
    .clk_i(clk), .reset_i(rst),
    .dec_valid_i(dec_valid), .dec_rd_wen_i(dec_wen), .dec_rd_addr_i(dec_rd),
    .dec_ready_o(dec_ready), .disp_ready_i(disp_ready),
    .ren_inst_valid_o(ren_iv), .disp_valid_o(disp_valid),
    .fl_empty_i(fl_empty), .fl_free_en_o(fl_en), .fl_free_addr_o(fl_addr),
    .cmt_free_en_i(cmt_en), .cmt_free_addr_i(cmt_addr), .cmt_ready_o(cmt_ready),
    .sq_free_en_i(sq_en), .sq_free_addr_i(sq_addr), .sq_ready_o(sq_ready),
    .flush_i(flush), .sq_done_i(sq_done), .stall_empty_cnt_o(stall_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = running, 1 = waiting for free list, 2 = flushing.
  int  m_mode;
  int  m_fq[$];
  bit  m_sq_seen;
  bit  m_dv;
  int  m_cnt;

  // Observations captured mid-cycle for directed checks.
  logic       o_dr, o_riv, o_fen, o_dv, o_cr, o_sr;
  logic [4:0] o_faddr;
  logic [15:0] o_cnt;
  int         got[$];

  task automatic model_reset();
    m_mode = 0; m_fq.delete(); m_sq_seen = 0; m_dv = 0; m_cnt = 0;
  endtask

  task automatic cycle();
    bit na, prio, full, dr, fire, riv, fen, cacc, sacc;
    int faddr, sz0;
    #2;
    na    = dec_wen && (dec_rd != 0);
    prio  = (m_fq.size() >= DEPTH - 1) || (m_mode == 2);
    full  = (m_fq.size() == DEPTH);
    dr    = !rst && m_mode == 0 && disp_ready && !flush && (!na || (!fl_empty && !prio));
    fire  = dec_valid && dr;
    riv   = fire && na;
    fen   = !rst && m_fq.size() != 0 && !riv;
    faddr = fen ? m_fq[0] : 0;
    chk("dec_ready", dec_ready, dr);
    chk("ren_inst_valid", ren_iv, riv);
    chk("fl_free_en", fl_en, fen);
    chk("fl_free_addr", fl_addr, faddr);
    chk("cmt_ready", cmt_ready, !rst && !full);
    chk("sq_ready", sq_ready, !rst && !full && !cmt_en);
    chk("disp_valid", disp_valid, m_dv && !flush && m_mode != 2);
    chk("stall_cnt", stall_cnt, m_cnt);
    chk("excl", fl_en & ren_iv, 0);
    o_dr = dec_ready; o_riv = ren_iv; o_fen = fl_en; o_faddr = fl_addr;
    o_dv = disp_valid; o_cr = cmt_ready; o_sr = sq_ready; o_cnt = stall_cnt;
    if (fl_en) got.push_back(int'(fl_addr));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      sz0  = m_fq.size();
      cacc = cmt_en && !full;
      sacc = sq_en && !full && !cmt_en;
      if (fen) void'(m_fq.pop_front());
      if (cacc) begin
        if (cmt_addr != 0) m_fq.push_back(int'(cmt_addr));
      end else if (sacc && sq_addr != 0) begin
        m_fq.push_back(int'(sq_addr));
      end
      if (dec_valid && na && fl_empty && m_cnt < CNT_MAX) m_cnt++;
      m_dv = fire;
      if (flush) begin
        m_mode = 2; m_sq_seen = 0;
      end else if (m_mode == 0) begin
        if (dec_valid && na && fl_empty) m_mode = 1;
      end else if (m_mode == 1) begin
        if (!fl_empty) m_mode = 0;
      end else begin
        if ((m_sq_seen || sq_done) && sz0 == 0) begin
          m_mode = 0; m_sq_seen = 0;
        end else begin
          m_sq_seen = m_sq_seen | sq_done;
        end
      end
    end
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; dec_wen = 0; dec_rd = 0; disp_ready = 1; fl_empty = 0;
    cmt_en = 0; cmt_addr = 0; sq_en = 0; sq_addr = 0; flush = 0; sq_done = 0;
  endtask

  initial begin
    int fires;
    bit ok;
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state.
    disp_ready = 0;
    cycle();
    chk("rst_dec_ready", o_dr, 0);
    chk("rst_stall_cnt", o_cnt, 0);
    chk("rst_fl_en", o_fen, 0);
    chk("rst_disp_valid", o_dv, 0);
    rst = 0; disp_ready = 1;
    cycle();

    // Fill: 31 allocating instructions back to back.
    fires = 0;
    for (int i = 1; i <= 31; i++) begin
      dec_valid = 1; dec_wen = 1; dec_rd = 5'(i); fl_empty = 0;
      cycle();
      if (o_dr && o_riv) fires++;
    end
    chk("fill_fires", fires, 31);

    // Instruction 32 meets an empty free list.
    dec_rd = 5'd5; fl_empty = 1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("stall_dec_ready", o_dr, 0);
      chk("stall_cnt_seq", o_cnt, k);
    end

    // Stall release via commit free of p7.
    cmt_en = 1; cmt_addr = 5'd7;
    cycle();
    chk("rel_cmt_ready", o_cr, 1);
    cmt_en = 0;
    cycle();
    chk("rel_free_en", o_fen, 1);
    chk("rel_free_addr", o_faddr, 7);
    fl_empty = 0;
    cycle();
    chk("rel_still_stalled", o_dr, 0);
    cycle();
    chk("rel_fire", o_dr & o_riv, 1);
    dec_valid = 0;
    cycle();

    // Exclusivity: allocation while four commit frees arrive.
    got.delete();
    for (int i = 0; i < 12; i++) begin
      dec_valid = (i < 6); dec_wen = 1; dec_rd = 5'((i % 31) + 1);
      cmt_en = (i < 4); cmt_addr = 5'(10 + i);
      cycle();
      if (i == 3) chk("excl_prio_block", o_dr, 0);
    end
    cmt_en = 0; dec_valid = 0;
    chk("excl_n", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("excl_order", got[i], 10 + i);

    // Arbitration: commit p5 and squash p9 together.
    got.delete();
    cmt_en = 1; cmt_addr = 5'd5; sq_en = 1; sq_addr = 5'd9;
    cycle();
    chk("arb_cmt_ready", o_cr, 1);
    chk("arb_sq_ready", o_sr, 0);
    cmt_en = 0;
    cycle();
    chk("arb_sq_ready2", o_sr, 1);
    sq_en = 0;
    repeat (3) cycle();
    chk("arb_n", got.size(), 2);
    if (got.size() == 2) begin
      chk("arb_first", got[0], 5);
      chk("arb_second", got[1], 9);
    end

    // Flush in the cycle after a fire.
    dec_valid = 1; dec_wen = 1; dec_rd = 5'd3;
    cycle();
    chk("fl_pre_fire", o_riv, 1);
    dec_valid = 0; flush = 1; sq_en = 1; sq_addr = 5'd12;
    cycle();
    chk("fl_disp_killed", o_dv, 0);
    flush = 0; sq_en = 0; dec_valid = 1; dec_wen = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("fl_blocked", o_dr, 0);
    end
    sq_done = 1;
    cycle();
    chk("fl_blocked_done", o_dr, 0);
    sq_done = 0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      cycle();
      if (o_dr) ok = 1;
    end
    chk("fl_resume", ok, 1);
    dec_valid = 0;

    // x0 destination and p0 free.
    dec_valid = 1; dec_wen = 1; dec_rd = 5'd0; fl_empty = 1;
    cycle();
    chk("x0_fire", o_dr, 1);
    chk("x0_no_alloc", o_riv, 0);
    dec_valid = 0; fl_empty = 0; cmt_en = 1; cmt_addr = 5'd0;
    cycle();
    chk("p0_accept", o_cr, 1);
    cmt_en = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("p0_dropped", o_fen, 0);
    end

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      rst        = ($urandom_range(0, 63) == 0);
      dec_valid  = $urandom_range(0, 1);
      dec_wen    = ($urandom_range(0, 3) != 0);
      dec_rd     = 5'($urandom_range(0, 31));
      disp_ready = ($urandom_range(0, 4) != 0);
      fl_empty   = ($urandom_range(0, 9) < 3);
      cmt_en     = ($urandom_range(0, 9) < 4);
      cmt_addr   = 5'($urandom_range(0, 31));
      sq_en      = ($urandom_range(0, 9) < 4);
      sq_addr    = 5'($urandom_range(0, 31));
      flush      = ($urandom_range(0, 19) == 0);
      sq_done    = ($urandom_range(0, 4) == 0);
      cycle();
    end
    idle();
    rst = 1;
    cycle();
    rst = 0;

    // Long stall saturates the counter.
    dec_valid = 1; dec_wen = 1; dec_rd = 5'd1; fl_empty = 1;
    for (int i = 0; i < CNT_MAX + 4; i++) cycle();
    chk("cnt_saturated", o_cnt, 16'hFFFF);
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rename_ctrl.md
# rename_ctrl

Sequencing controller for the rename stage and its physical-register free list. It gates decode→rename handshakes, stalls when no physical register is free, and merges the commit-retire and squash-walk free streams into the free list's single free port. It also enforces that the free list sees at most one pointer update per cycle: allocate or free, never both. It sits between decode, the rename/RAT block, the free list, the ROB commit port and dispatch.

## Interface
- FREE_Q_DEPTH, 4: entries in the internal free-request queue (power of two, ≥2)
- PREG_W, 5: physical register address width
- CNT_W, 16: width of the saturating stall counter
- clk_i  in  1  clock; one clock domain
- reset_i  in  1  synchronous, active-high reset
- dec_valid_i  in  1  decode presents an instruction
- dec_rd_wen_i  in  1  instruction writes an architectural rd
- dec_rd_addr_i  in  5  architectural rd
- dec_ready_o  out  1  rename accepts this cycle (fire = dec_valid_i & dec_ready_o)
- disp_ready_i  in  1  dispatch has ≥2 free slots (credit)
- ren_inst_valid_o  out  1  drives rename inst_valid; equals fire & needs_alloc
- disp_valid_o  out  1  registered fire; the renamed result is valid toward dispatch
- fl_empty_i  in  1  free list empty
- fl_free_en_o  out  1  free-list free strobe
- fl_free_addr_o  out  PREG_W  register being freed
- cmt_free_en_i / cmt_free_addr_i  in  1 / PREG_W  ROB retires and releases an old physical register
- cmt_ready_o  out  1  commit free request accepted
- sq_free_en_i / sq_free_addr_i  in  1 / PREG_W  squash walk releases a physical register
- sq_ready_o  out  1  squash free request accepted
- flush_i  in  1  mispredict/exception flush
- sq_done_i  in  1  squash walk complete
- stall_empty_cnt_o  out  CNT_W  cycles stalled on an empty free list

## Operation
- needs_alloc = dec_rd_wen_i & (dec_rd_addr_i != 0). Instructions that do not write rd, or that target x0, pass through without allocating.
- States:
  - RUN: normal operation.
  - STALL: entered when dec_valid_i & needs_alloc & fl_empty_i.
  - FLUSH: flushing in-flight work.
- Transitions:
  - RUN→STALL: on the STALL condition above.
  - STALL→RUN: when fl_empty_i = 0.
  - Any state→FLUSH: when flush_i = 1. Flush has top priority.
  - FLUSH→RUN: in the cycle after sq_done_i = 1 and the free queue is empty.
- free_prio = (queue count ≥ FREE_Q_DEPTH−1) | (state == FLUSH).
- dec_ready_o = (state==RUN) & disp_ready_i & !flush_i & (!needs_alloc | (!fl_empty_i & !free_prio)).
- Free port: dequeue one entry when the queue is non-empty and ren_inst_valid_o = 0. fl_free_en_o and ren_inst_valid_o are never both 1.
- Enqueue: at most one request per cycle.
  - Commit has priority over squash.
  - cmt_ready_o = !full.
  - sq_ready_o = !full & !cmt_free_en_i.
  - An enqueue and a dequeue in the same cycle leave the count unchanged.
- Free requests with address 0 are accepted and then dropped; they are not enqueued.
- stall_empty_cnt_o increments each cycle with dec_valid_i & needs_alloc & fl_empty_i, and saturates at all-ones.

## Timing
- All outputs are 0 after reset: state RUN, queue empty, counter 0.
- dec_ready_o, ren_inst_valid_o, cmt_ready_o and sq_ready_o are combinational.
- disp_valid_o is fire registered by 1 cycle, aligned with the registered prs/prd outputs of rename.
- fl_free_en_o and fl_free_addr_o come from registered queue head state. The queue is first-word-fall-through.
- Minimum latency from a free request to the free strobe: 1 cycle.
- In FLUSH, disp_valid_o is forced to 0 in the first FLUSH cycle, killing any fire from the preceding cycle.
- Queue pointers wrap modulo FREE_Q_DEPTH, with a separate count register of width log2(FREE_Q_DEPTH)+1.
- When full, requests are held off through the ready signals and never dropped.
- Reset asserted mid-flush or mid-stall returns to RUN, empties the queue and loses pending frees. The free list resets in the same cycle.

## Structure
- Package rename_pkg holds:
  - PREG_W and ARCH_W = 5
  - the state enum {RUN, STALL, FLUSH}
  - the default FREE_Q_DEPTH
- Sub-module free_req_fifo: parameterised first-word-fall-through queue with push/pop/full/empty/count.
- Arbitration, FSM and counter live in rename_ctrl.

## Test plan
- Fill: reset, then 31 back-to-back instructions with rd=1..31. Response: 31 fires, ren_inst_valid_o each cycle. Instruction 32 with fl_empty_i=1 stalls, dec_ready_o=0, and stall_empty_cnt_o counts 1,2,3…
- Stall release: from that stall, a commit free of p7 is accepted. Response: fl_free_en_o=1 with addr 7 exactly 1 cycle later. The stall ends the following cycle and the held instruction fires.
- Exclusivity: continuous allocation while 4 commit frees arrive. Response: the queue reaches 3, free_prio blocks dec_ready_o, and frees drain in order. fl_free_en_o & ren_inst_valid_o is never 1.
- Arbitration: commit and squash requests for p5 and p9 in the same cycle. Response: p5 enqueued, sq_ready_o=0, p9 accepted next cycle, frees emitted in the order 5, 9.
- Flush: flush_i in the cycle after a fire. Response: disp_valid_o=0, dec_ready_o=0 until sq_done_i is seen and the queue has drained, then RUN resumes.
- x0 and edge cases:
  - An rd=0 instruction fires with ren_inst_valid_o=0.
  - A free request for p0 is accepted but never emitted.
  - The stall counter saturates at 0xFFFF when CNT_W=16 after a forced long stall.
